// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: decode/miss/branch inputs and control/forwarding outputs of the hazard unit
// Signals:
//   id_*                      : decode-stage instruction fields (valid, sources, destination, flags)
//   ex_br_taken, i_miss, d_miss : redirect and cache-miss requests
//   stall_if, stall_id, bubble_ex, flush, freeze : pipeline control
//   mem_to_ex_fwd1/2, wb_to_ex_fwd1/2           : EX operand forwarding selects
//   state, stall_cnt          : controller state and saturating IF-stall cycle count
// Modports: master drives the inputs and observes the outputs; slave is the hazard unit.
interface hazard_ctrl_if;
   logic        id_valid;
   logic [4:0]  id_rs1;
   logic [4:0]  id_rs2;
   logic        id_uses_rs1;
   logic        id_uses_rs2;
   logic [4:0]  id_rd;
   logic        id_reg_write;
   logic        id_is_load;
   logic        ex_br_taken;
   logic        i_miss;
   logic        d_miss;
   logic        stall_if;
   logic        stall_id;
   logic        bubble_ex;
   logic        flush;
   logic        freeze;
   logic        mem_to_ex_fwd1;
   logic        mem_to_ex_fwd2;
   logic        wb_to_ex_fwd1;
   logic        wb_to_ex_fwd2;
   logic [1:0]  state;
   logic [15:0] stall_cnt;
   modport master (
      output id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_rd, id_reg_write, id_is_load,
      output ex_br_taken, i_miss, d_miss,
      input  stall_if, stall_id, bubble_ex, flush, freeze,
      input  mem_to_ex_fwd1, mem_to_ex_fwd2, wb_to_ex_fwd1, wb_to_ex_fwd2, state, stall_cnt
   );
   modport slave (
      input  id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_rd, id_reg_write, id_is_load,
      input  ex_br_taken, i_miss, d_miss,
      output stall_if, stall_id, bubble_ex, flush, freeze,
      output mem_to_ex_fwd1, mem_to_ex_fwd2, wb_to_ex_fwd1, wb_to_ex_fwd2, state, stall_cnt
   );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard unit -- stalls, bubbles, flushes, freeze and EX operand forwarding
// Ports:
//   clk   : pipeline clock, state updates on the rising edge
//   rst_n : asynchronous active-low reset
//   h     : hazard_ctrl_if.slave -- decode fields and miss/branch requests in; control, forwarding,
//           registered state and saturating stall count out
module hazard_ctrl (
   input logic          clk,
   input logic          rst_n,
   hazard_ctrl_if.slave h
);
   typedef enum logic [1:0] {RUN = 2'b00, IMISS = 2'b01, DMISS = 2'b10, LDSTALL = 2'b11} state_t;
   typedef struct packed {
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic       uses1;
      logic       uses2;
      logic [4:0] rd;
      logic       reg_write;
      logic       is_load;
   } ex_t;
   typedef struct packed {
      logic [4:0] rd;
      logic       reg_write;
   } wr_t;
   state_t      state_q, state_d;
   ex_t         ex_q;
   wr_t         mem_q, wb_q;
   logic [15:0] cnt_q;
   logic        hazard, stall_if, stall_id, bubble_ex, flush, freeze, kill;
   logic        mem1, mem2, wb1, wb2;
   // Every control output is gated by rst_n so outputs read 0 while reset is held.
   always_comb begin
      hazard    = h.id_valid & ex_q.is_load & ex_q.reg_write & (ex_q.rd != 5'd0) &
                  ((h.id_uses_rs1 & (h.id_rs1 == ex_q.rd)) | (h.id_uses_rs2 & (h.id_rs2 == ex_q.rd)));
      state_d   = h.d_miss ? DMISS : h.i_miss ? IMISS : hazard ? LDSTALL : RUN;
      freeze    = rst_n & h.d_miss;
      flush     = rst_n & ~h.d_miss & h.ex_br_taken;
      stall_if  = rst_n & (h.d_miss | h.i_miss | (~h.ex_br_taken & hazard));
      stall_id  = rst_n & (h.d_miss | (~h.ex_br_taken & (h.i_miss | hazard)));
      bubble_ex = rst_n & ~h.d_miss & ~h.ex_br_taken & (h.i_miss | hazard);
      kill      = bubble_ex | flush | ~h.id_valid;
      mem1      = ex_q.uses1 & mem_q.reg_write & (mem_q.rd != 5'd0) & (mem_q.rd == ex_q.rs1);
      mem2      = ex_q.uses2 & mem_q.reg_write & (mem_q.rd != 5'd0) & (mem_q.rd == ex_q.rs2);
      wb1       = ex_q.uses1 & wb_q.reg_write & (wb_q.rd != 5'd0) & (wb_q.rd == ex_q.rs1) & ~mem1;
      wb2       = ex_q.uses2 & wb_q.reg_write & (wb_q.rd != 5'd0) & (wb_q.rd == ex_q.rs2) & ~mem2;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= RUN;
      else state_q <= state_d;
   end
   // Shadow pipeline mirrors EX/MEM/WB; a frozen pipe holds every stage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
         ex_q  <= '0;
         mem_q <= '0;
         wb_q  <= '0;
      end else begin
         if (stall_if && cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
         if (!freeze) begin
            wb_q  <= mem_q;
            mem_q <= {ex_q.rd, ex_q.reg_write};
            ex_q  <= kill ? '0 : {h.id_rs1, h.id_rs2, h.id_uses_rs1, h.id_uses_rs2,
                                  h.id_rd, h.id_reg_write, h.id_is_load};
         end
      end
   end
   assign h.stall_if       = stall_if;
   assign h.stall_id       = stall_id;
   assign h.bubble_ex      = bubble_ex;
   assign h.flush          = flush;
   assign h.freeze         = freeze;
   assign h.mem_to_ex_fwd1 = mem1 & ~freeze;
   assign h.mem_to_ex_fwd2 = mem2 & ~freeze;
   assign h.wb_to_ex_fwd1  = wb1 & ~freeze;
   assign h.wb_to_ex_fwd2  = wb2 & ~freeze;
   assign h.state          = state_q;
   assign h.stall_cnt      = cnt_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: self-checking bench for hazard_ctrl (vector table, corner sequences, random vs model)
module tb_hazard_ctrl;
   typedef struct packed {
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic       u1;
      logic       u2;
      logic [4:0] rd;
      logic       rw;
      logic       ld;
   } instr_t;
   typedef struct {
      logic [4:0] p_rd;
      logic       p_rw;
      logic       p_ld;
      logic       v;
      logic [4:0] rs1;
      logic       u1;
      logic [4:0] rs2;
      logic       u2;
      logic       br;
      logic       im;
      logic       dm;
      logic [4:0] exp;
   } vec_t;
   logic   clk = 0;
   logic   rst_n = 1;
   int     n_vec = 0;
   int     n_err = 0;
   instr_t m_ex, m_mem, m_wb;
   int     m_state, m_cnt;
   vec_t   vecs[15];
   hazard_ctrl_if hif ();
   hazard_ctrl dut (.clk(clk), .rst_n(rst_n), .h(hif.slave));
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: instructions flow through EX/MEM/WB records, outputs from the priority rules.
   function automatic logic m_hz();
      return hif.id_valid && m_ex.ld && m_ex.rw && m_ex.rd != 0 &&
             ((hif.id_uses_rs1 && hif.id_rs1 == m_ex.rd) || (hif.id_uses_rs2 && hif.id_rs2 == m_ex.rd));
   endfunction
   // {stall_if, stall_id, bubble_ex, flush, freeze}
   function automatic logic [4:0] m_ctl();
      if (!rst_n) return 5'b00000;
      if (hif.d_miss) return 5'b11001;
      if (hif.ex_br_taken) return {hif.i_miss, 4'b0010};
      if (hif.i_miss || m_hz()) return 5'b11100;
      return 5'b00000;
   endfunction
   // {from_mem, from_wb} for one operand
   function automatic logic [1:0] m_src(input logic [4:0] rs, input logic u);
      if (!u) return 2'b00;
      if (m_mem.rw && m_mem.rd != 0 && m_mem.rd == rs) return 2'b10;
      if (m_wb.rw && m_wb.rd != 0 && m_wb.rd == rs) return 2'b01;
      return 2'b00;
   endfunction
   function automatic logic [3:0] m_fwd();
      if (hif.d_miss || !rst_n) return 4'b0000;
      return {m_src(m_ex.rs1, m_ex.u1), m_src(m_ex.rs2, m_ex.u2)};
   endfunction
   function automatic logic [4:0] act_ctl();
      return {hif.stall_if, hif.stall_id, hif.bubble_ex, hif.flush, hif.freeze};
   endfunction
   function automatic logic [3:0] act_fwd();
      return {hif.mem_to_ex_fwd1, hif.wb_to_ex_fwd1, hif.mem_to_ex_fwd2, hif.wb_to_ex_fwd2};
   endfunction

   task automatic m_reset();
      m_ex = '0;
      m_mem = '0;
      m_wb = '0;
      m_state = 0;
      m_cnt = 0;
   endtask
   task automatic clr_in();
      hif.id_valid = 0;
      hif.id_rs1 = 0;
      hif.id_rs2 = 0;
      hif.id_uses_rs1 = 0;
      hif.id_uses_rs2 = 0;
      hif.id_rd = 0;
      hif.id_reg_write = 0;
      hif.id_is_load = 0;
      hif.ex_br_taken = 0;
      hif.i_miss = 0;
      hif.d_miss = 0;
   endtask
   task automatic set_id(input logic v, input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                         input logic u2, input logic [4:0] rd, input logic rw, input logic ld);
      hif.id_valid = v;
      hif.id_rs1 = rs1;
      hif.id_uses_rs1 = u1;
      hif.id_rs2 = rs2;
      hif.id_uses_rs2 = u2;
      hif.id_rd = rd;
      hif.id_reg_write = rw;
      hif.id_is_load = ld;
   endtask
   task automatic do_reset();
      clr_in();
      rst_n = 0;
      m_reset();
      repeat (2) @(posedge clk);
      #1 rst_n = 1;
   endtask
   task automatic sample(input bit en);
      @(negedge clk);
      if (en) begin
         chk("ctl", act_ctl(), m_ctl());
         chk("fwd", act_fwd(), m_fwd());
         chk("state", hif.state, m_state);
         chk("stall_cnt", hif.stall_cnt, m_cnt);
      end
   endtask
   task automatic adv();
      logic [4:0] c;
      logic       hz;
      instr_t     id;
      @(posedge clk);
      c = m_ctl();
      hz = m_hz();
      id = '{hif.id_rs1, hif.id_rs2, hif.id_uses_rs1, hif.id_uses_rs2, hif.id_rd, hif.id_reg_write, hif.id_is_load};
      m_state = hif.d_miss ? 2 : hif.i_miss ? 1 : hz ? 3 : 0;
      if (c[4] && m_cnt < 65535) m_cnt++;
      if (!c[0]) begin
         m_wb = m_mem;
         m_mem = m_ex;
         m_ex = (c[2] || c[1] || !hif.id_valid) ? '0 : id;
      end
      #1;
   endtask

   initial begin
      // p_rd p_rw p_ld | v rs1 u1 rs2 u2 | br im dm | {stall_if,stall_id,bubble,flush,freeze}
      vecs[0]  = '{5, 1, 1, 1, 0, 0, 5, 1, 0, 0, 0, 5'b11100};
      vecs[1]  = '{5, 1, 1, 1, 5, 1, 0, 0, 0, 0, 0, 5'b11100};
      vecs[2]  = '{5, 1, 1, 1, 5, 0, 5, 0, 0, 0, 0, 5'b00000};
      vecs[3]  = '{0, 1, 1, 1, 0, 1, 0, 1, 0, 0, 0, 5'b00000};
      vecs[4]  = '{5, 1, 0, 1, 5, 1, 5, 1, 0, 0, 0, 5'b00000};
      vecs[5]  = '{5, 0, 1, 1, 5, 1, 5, 1, 0, 0, 0, 5'b00000};
      vecs[6]  = '{5, 1, 1, 0, 5, 1, 5, 1, 0, 0, 0, 5'b00000};
      vecs[7]  = '{5, 1, 1, 1, 5, 1, 0, 0, 1, 0, 0, 5'b00010};
      vecs[8]  = '{5, 1, 1, 1, 5, 1, 0, 0, 1, 1, 0, 5'b10010};
      vecs[9]  = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 5'b11100};
      vecs[10] = '{0, 0, 0, 1, 0, 0, 0, 0, 1, 1, 1, 5'b11001};
      vecs[11] = '{0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 5'b00010};
      vecs[12] = '{5, 1, 1, 1, 5, 1, 0, 0, 0, 0, 1, 5'b11001};
      vecs[13] = '{5, 1, 1, 1, 6, 1, 5, 1, 0, 1, 0, 5'b11100};
      vecs[14] = '{5, 1, 1, 1, 6, 1, 4, 1, 0, 0, 0, 5'b00000};
      clr_in();
      m_reset();
      hif.d_miss = 1;
      hif.i_miss = 1;
      hif.ex_br_taken = 1;
      hif.id_valid = 1;
      #1 rst_n = 0;
      #2;
      chk("rst_ctl", act_ctl(), 0);
      chk("rst_fwd", act_fwd(), 0);
      chk("rst_state", hif.state, 0);
      chk("rst_cnt", hif.stall_cnt, 0);
      foreach (vecs[i]) begin
         do_reset();
         set_id(1, 0, 0, 0, 0, vecs[i].p_rd, vecs[i].p_rw, vecs[i].p_ld);
         sample(1);
         adv();
         set_id(vecs[i].v, vecs[i].rs1, vecs[i].u1, vecs[i].rs2, vecs[i].u2, 0, 0, 0);
         hif.ex_br_taken = vecs[i].br;
         hif.i_miss = vecs[i].im;
         hif.d_miss = vecs[i].dm;
         sample(1);
         chk($sformatf("vec%0d", i), act_ctl(), vecs[i].exp);
      end
      // load-use: lw x5, then reader of x5 via rs2
      do_reset();
      set_id(1, 0, 0, 0, 0, 5, 1, 1);
      sample(1);
      adv();
      set_id(1, 1, 0, 5, 1, 7, 1, 0);
      sample(1);
      chk("lu_T_stall", {hif.stall_if, hif.stall_id, hif.bubble_ex}, 3'b111);
      adv();
      sample(1);
      chk("lu_T1_state", hif.state, 3);
      chk("lu_T1_stall", {hif.stall_if, hif.stall_id}, 2'b00);
      adv();
      set_id(0, 0, 0, 0, 0, 0, 0, 0);
      sample(1);
      chk("lu_T2_wb2", hif.wb_to_ex_fwd2, 1);
      chk("lu_T2_mem2", hif.mem_to_ex_fwd2, 0);
      adv();
      // back-to-back ALU writes to x3, then reader of x3; then x0 writer and reader
      do_reset();
      set_id(1, 0, 0, 0, 0, 3, 1, 0);
      sample(1);
      adv();
      sample(1);
      adv();
      set_id(1, 3, 1, 0, 0, 8, 1, 0);
      sample(1);
      adv();
      set_id(0, 0, 0, 0, 0, 0, 0, 0);
      sample(1);
      chk("alu_mem1", hif.mem_to_ex_fwd1, 1);
      chk("alu_wb1", hif.wb_to_ex_fwd1, 0);
      adv();
      set_id(1, 0, 0, 0, 0, 0, 1, 0);
      sample(1);
      adv();
      set_id(1, 0, 1, 0, 0, 9, 1, 0);
      sample(1);
      adv();
      set_id(0, 0, 0, 0, 0, 0, 0, 0);
      sample(1);
      chk("x0_fwd", {hif.mem_to_ex_fwd1, hif.wb_to_ex_fwd1}, 2'b00);
      adv();
      // d_miss for 4 cycles with a taken branch in EX
      do_reset();
      hif.ex_br_taken = 1;
      hif.d_miss = 1;
      for (int k = 1; k <= 4; k++) begin
         sample(1);
         chk("dm_freeze", hif.freeze, 1);
         chk("dm_flush", hif.flush, 0);
         if (k > 1) chk("dm_state", hif.state, 2);
         adv();
      end
      hif.d_miss = 0;
      sample(1);
      chk("dm_after_flush", hif.flush, 1);
      chk("dm_after_cnt", hif.stall_cnt, 4);
      adv();
      // i_miss for 3 cycles, branch on the 2nd
      do_reset();
      hif.i_miss = 1;
      sample(1);
      chk("im1_bubble", hif.bubble_ex, 1);
      adv();
      hif.ex_br_taken = 1;
      sample(1);
      chk("im2_ctl", {hif.flush, hif.stall_if, hif.bubble_ex}, 3'b110);
      adv();
      hif.ex_br_taken = 0;
      sample(1);
      chk("im3_bubble", hif.bubble_ex, 1);
      adv();
      // stall counter saturation, then reset mid-miss
      do_reset();
      hif.i_miss = 1;
      for (int k = 0; k < 65534; k++) begin
         sample(0);
         adv();
      end
      sample(1);
      chk("sat_fffe", hif.stall_cnt, 16'hFFFE);
      adv();
      sample(1);
      chk("sat_ffff", hif.stall_cnt, 16'hFFFF);
      adv();
      sample(1);
      chk("sat_hold", hif.stall_cnt, 16'hFFFF);
      #1 rst_n = 0;
      m_reset();
      #1;
      chk("arst_ctl", act_ctl(), 0);
      chk("arst_fwd", act_fwd(), 0);
      chk("arst_state", hif.state, 0);
      chk("arst_cnt", hif.stall_cnt, 0);
      @(posedge clk);
      #1 rst_n = 1;
      sample(1);
      chk("post_rst_state", hif.state, 0);
      chk("post_rst_stall", hif.stall_if, 1);
      adv();
      sample(1);
      chk("post_rst_imiss", hif.state, 1);
      adv();
      // randomized traffic against the model
      do_reset();
      for (int k = 0; k < 3000; k++) begin
         set_id($urandom_range(0, 7) != 0, 5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         hif.ex_br_taken = $urandom_range(0, 7) == 0;
         hif.i_miss = $urandom_range(0, 7) == 0;
         hif.d_miss = $urandom_range(0, 9) == 0;
         sample(1);
         adv();
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 clk  in  1  pipeline clock; all state updates on rising edge.
REQ-002 rst_n  in  1  asynchronous, active-low reset.
REQ-003 id_valid  in  1  decode stage holds a valid instruction.
REQ-004 id_rs1, id_rs2  in  5 each  decode source register indices.
REQ-005 id_uses_rs1, id_uses_rs2  in  1 each  decode instruction reads that source.
REQ-006 id_rd  in  5; id_reg_write  in  1; id_is_load  in  1  decode destination, write enable, load flag.
REQ-007 ex_br_taken  in  1  branch/jump in EX redirects the PC this cycle.
REQ-008 i_miss  in  1  I-cache miss pending; d_miss  in  1  D-cache miss pending.
REQ-009 stall_if, stall_id  out  1 each  hold PC and IF/ID register.
REQ-010 bubble_ex  out  1  load a zero control word into DE/EX.
REQ-011 flush  out  1  squash IF/ID and DE/EX contents.
REQ-012 freeze  out  1  hold every pipeline register, including EX/MEM and MEM/WB.
REQ-013 mem_to_ex_fwd1/2, wb_to_ex_fwd1/2  out  1 each  EX operand forwarding selects.
REQ-014 state  out  2  00 RUN, 01 IMISS, 10 DMISS, 11 LDSTALL.
REQ-015 stall_cnt  out  16  saturating count of cycles with stall_if=1.

Function
REQ-016 A shadow pipeline holds {rs1, rs2, uses1, uses2, rd, reg_write, is_load} for EX, plus {rd, reg_write, is_load} for MEM and WB.
- Advance when freeze=0: WB<=MEM, MEM<=EX, EX<=ID fields.
- EX is loaded with zeros when bubble_ex=1, flush=1 or id_valid=0.
REQ-017 The shadow pipeline holds all stages when freeze=1.
REQ-018 Load-use hazard exists when id_valid, EX.is_load, EX.reg_write, EX.rd!=0, and (id_uses_rs1 with id_rs1==EX.rd, or id_uses_rs2 with id_rs2==EX.rd).
REQ-019 Output priority, highest first (combinational from current state and inputs):
- d_miss: freeze=1, stall_if=stall_id=1, all others 0.
- ex_br_taken: flush=1, stall_id=0, bubble_ex=0, stall_if=i_miss.
- i_miss: stall_if=stall_id=1, bubble_ex=1.
- load-use hazard: stall_if=stall_id=1, bubble_ex=1.
- otherwise all 0.
REQ-020 FSM next state is DMISS if d_miss; else IMISS if i_miss; else LDSTALL if a load-use hazard is present; else RUN.
- The output state reflects the registered value.
- An i_miss that arrives during DMISS enters IMISS the cycle after d_miss falls, if i_miss is still high.
REQ-021 mem_to_ex_fwdN=1 when EX.usesN, MEM.reg_write, MEM.rd!=0 and MEM.rd==EX.rsN.
REQ-022 wb_to_ex_fwdN=1 when EX.usesN, WB.reg_write, WB.rd!=0, WB.rd==EX.rsN and mem_to_ex_fwdN=0.
- MEM forwarding has priority over WB forwarding.
REQ-023 All forwarding selects are 0 while freeze=1.
REQ-024 Register x0 never produces a hazard or a forward.
REQ-025 stall_cnt increments by 1 each cycle stall_if=1, saturates at 16'hFFFF, and does not wrap.
REQ-026 Load-use stall lasts exactly one cycle, because the load then sits in MEM with EX bubbled.
- The consumer takes the WB forward on its EX cycle.
REQ-027 ex_br_taken together with a load-use hazard gives flush only; the dependent instruction is squashed.
REQ-028 ex_br_taken together with d_miss gives freeze only.
- The branch stays in EX and is serviced after d_miss falls.

Reset
REQ-029 While rst_n=0, and immediately on its assertion:
- state=RUN, stall_cnt=0, all shadow-pipeline fields=0.
- All outputs are 0.
REQ-030 Reset asserted mid-stall or mid-miss abandons that stall; the first cycle after release evaluates inputs from RUN.

Verification
REQ-031 Load-use case:
- Stimulus: lw x5 enters EX; ID instruction reads x5 via rs2.
- Cycle T: stall_if=stall_id=bubble_ex=1.
- T+1: state=LDSTALL, stalls 0.
- T+2: consumer is in EX with wb_to_ex_fwd2=1, mem_to_ex_fwd2=0.
REQ-032 Back-to-back ALU writes to x3, then a reader of x3 via rs1: mem_to_ex_fwd1=1 and wb_to_ex_fwd1=0.
- A write to x0 followed by a reader of x0 gives no forward.
REQ-033 d_miss held for 4 cycles with ex_br_taken=1:
- freeze=1 and flush=0 for 4 cycles; state=DMISS.
- flush=1 on the cycle after d_miss falls; stall_cnt has advanced by 4.
REQ-034 i_miss for 3 cycles, with ex_br_taken on the 2nd cycle:
- Cycle 2: flush=1, stall_if=1, bubble_ex=0.
- Cycles 1 and 3: bubble_ex=1.
REQ-035 stall_cnt preset near 16'hFFFE by a long i_miss: it reaches 16'hFFFF and holds.
- rst_n pulsed low mid-miss: stall_cnt=0, state=RUN, outputs 0 asynchronously.
